// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle unsigned multiply/divide sequencer.
// Borrows the execute-stage ALU while busy: one add per cycle for
// shift-and-add multiply, one subtract per cycle for restoring divide.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request, start_ready high, ALU not driven
// MUL   | one shift-and-add step per cycle, XLEN steps
// DIV   | one restoring-division step per cycle, XLEN steps
// DONE  | result held on result, result_valid high until result_ready
//
// The hi/lo pair doubles as rem/quo during divide, so the result select
// is simply funct[0] ? hi : lo for all four operations.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [1:0]      funct,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic [3:0]      alu_status
);

  localparam int         CW      = 6;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] hi_q;     // multiply high word / divide remainder
  logic [XLEN-1:0] lo_q;     // multiply low word / divide quotient
  logic [XLEN-1:0] opnd_q;   // multiplicand or divisor
  logic            sel_hi_q; // funct[0]: result comes from hi

  logic [XLEN-1:0] div_s;
  logic            div_top;
  logic            div_ge;
  logic            last_step;
  logic            unused_status;

  // Shifted partial remainder; the bit shifted out of rem is rtop.
  assign div_s     = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
  assign div_top   = hi_q[XLEN-1];
  assign div_ge    = div_top | ~alu_status[0];
  assign last_step = (cnt_q == CW'(1));

  // Only the carry/borrow flag is needed from the ALU status.
  assign unused_status = ^alu_status[3:1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, handshake outputs and ALU operand drive.
  always_comb begin
    state_d      = state_q;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b0;
    result       = '0;
    alu_op       = ALU_ADD;
    alu_a        = '0;
    alu_b        = '0;
    case (state_q)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          if (!funct[1]) begin
            state_d = S_MUL;
          end else if (op_b == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        busy  = 1'b1;
        alu_a = hi_q;
        alu_b = lo_q[0] ? opnd_q : '0;
        if (last_step) begin
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        busy   = 1'b1;
        alu_op = ALU_SUB;
        alu_a  = div_s;
        alu_b  = opnd_q;
        if (last_step) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        result_valid = 1'b1;
        result       = sel_hi_q ? hi_q : lo_q;
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand capture on accept and one arithmetic step per busy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      sel_hi_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_valid) begin
            sel_hi_q <= funct[0];
            cnt_q    <= CW'(XLEN);
            if (!funct[1]) begin
              hi_q   <= '0;
              lo_q   <= op_b;
              opnd_q <= op_a;
            end else if (op_b == '0) begin
              // Divide by zero: preset quotient all ones, remainder = dividend.
              hi_q   <= op_a;
              lo_q   <= '1;
              opnd_q <= op_b;
            end else begin
              hi_q   <= '0;
              lo_q   <= op_a;
              opnd_q <= op_b;
            end
          end
        end
        S_MUL: begin
          {hi_q, lo_q} <= {alu_status[0], alu_result, lo_q[XLEN-1:1]};
          cnt_q        <= cnt_q - CW'(1);
        end
        S_DIV: begin
          hi_q  <= div_ge ? alu_result : div_s;
          lo_q  <= {lo_q[XLEN-2:0], div_ge};
          cnt_q <= cnt_q - CW'(1);
        end
        default: begin
          cnt_q <= cnt_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq with a behavioural combinational ALU.
module tb_muldiv_seq;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            start_valid;
  logic            start_ready;
  logic [1:0]      funct;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            result_valid;
  logic            result_ready;
  logic [XLEN-1:0] result;
  logic            busy;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_result;
  logic [3:0]      alu_status;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .funct        (funct),
    .op_a         (op_a),
    .op_b         (op_b),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .busy         (busy),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_status   (alu_status)
  );

  // Clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: SUB on 1010, ADD otherwise; status bit 0 is carry / a<b.
  always_comb begin
    logic [XLEN:0] sum;
    sum        = '0;
    alu_result = '0;
    alu_status = '0;
    if (alu_op == 4'b1010) begin
      alu_result    = alu_a - alu_b;
      alu_status[0] = (alu_a < alu_b);
    end else begin
      sum           = {1'b0, alu_a} + {1'b0, alu_b};
      alu_result    = sum[XLEN-1:0];
      alu_status[0] = sum[XLEN];
    end
    alu_status[1] = (alu_result == '0);
    alu_status[2] = alu_result[XLEN-1];
  end

  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: pops an expected value every time a result is consumed.
  always @(negedge clk) begin
    logic [XLEN-1:0] e;
    if (rst_n && result_valid && result_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got %h expected none", result);
      end else begin
        e = exp_q.pop_front();
        if (result !== e) begin
          errors++;
          $display("FAIL result got %h expected %h", result, e);
        end
      end
    end
  end

  // From just after the accept edge, count edges until result_valid.
  task automatic wait_valid(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!result_valid && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Issue one operation and check latency / busy length; result goes to the scoreboard.
  task automatic run_op(input string name, input logic [1:0] f, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                        input int exp_lat, input int exp_busy);
    int lat;
    int bcnt;
    chk({name, "_start_ready"}, XLEN'(start_ready), XLEN'(1));
    start_valid = 1'b1;
    funct       = f;
    op_a        = a;
    op_b        = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    op_a        = $urandom;
    op_b        = $urandom;
    wait_valid(lat, bcnt);
    chk({name, "_latency"}, XLEN'(lat), XLEN'(exp_lat));
    chk({name, "_busy_cycles"}, XLEN'(bcnt), XLEN'(exp_busy));
    @(posedge clk);
    #1;
    chk({name, "_back_idle"}, XLEN'(start_ready), XLEN'(1));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_start_ready"}, XLEN'(start_ready), XLEN'(1));
    chk({name, "_result_valid"}, XLEN'(result_valid), XLEN'(0));
    chk({name, "_busy"}, XLEN'(busy), XLEN'(0));
    chk({name, "_result"}, result, '0);
    chk({name, "_alu_a"}, alu_a, '0);
    chk({name, "_alu_b"}, alu_b, '0);
    chk({name, "_alu_op"}, XLEN'(alu_op), XLEN'(4'b0010));
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int lat;
    int bcnt;
    rst_n        = 1'b0;
    start_valid  = 1'b0;
    result_ready = 1'b1;
    funct        = 2'b00;
    op_a         = '0;
    op_b         = '0;
    #2;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("mul_7x6",       2'b00, 32'd7,         32'd6,         32'd42,        XLEN, XLEN);
    run_op("mulhu_7x6",     2'b01, 32'd7,         32'd6,         32'd0,         XLEN, XLEN);
    run_op("mulhu_max",     2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  XLEN, XLEN);
    run_op("mul_max",       2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  XLEN, XLEN);
    run_op("divu_100_7",    2'b10, 32'd100,       32'd7,         32'd14,        XLEN, XLEN);
    run_op("remu_100_7",    2'b11, 32'd100,       32'd7,         32'd2,         XLEN, XLEN);
    run_op("divu_max_1",    2'b10, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  XLEN, XLEN);
    run_op("remu_max_1",    2'b11, 32'hFFFFFFFF,  32'd1,         32'd0,         XLEN, XLEN);
    run_op("divu_msb_max",  2'b10, 32'h80000000,  32'hFFFFFFFF,  32'd0,         XLEN, XLEN);
    run_op("remu_msb_max",  2'b11, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  XLEN, XLEN);
    // Divide by zero: DONE is entered on the accept edge, no busy cycles.
    run_op("divu_by_zero",  2'b10, 32'h1234,      32'd0,         32'hFFFFFFFF,  0,    0);
    run_op("remu_by_zero",  2'b11, 32'h1234,      32'd0,         32'h1234,      0,    0);

    // Backpressure: result held for 10 cycles, start_valid pulse ignored.
    result_ready = 1'b0;
    start_valid  = 1'b1;
    funct        = 2'b00;
    op_a         = 32'd12;
    op_b         = 32'd11;
    exp_q.push_back(32'd132);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    wait_valid(lat, bcnt);
    chk("bp_latency", XLEN'(lat), XLEN'(XLEN));
    for (int i = 0; i < 10; i++) begin
      chk("bp_result_hold", result, 32'd132);
      chk("bp_start_ready", XLEN'(start_ready), XLEN'(0));
      start_valid = (i == 3);
      op_a        = 32'd3;
      op_b        = 32'd0;
      funct       = 2'b10;
      @(posedge clk);
      #1;
    end
    start_valid = 1'b0;
    chk("bp_still_valid", XLEN'(result_valid), XLEN'(1));
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_ready", XLEN'(start_ready), XLEN'(1));
    chk("bp_idle_valid", XLEN'(result_valid), XLEN'(0));
    chk("bp_no_accept", XLEN'(busy), XLEN'(0));

    // Reset during step 15 of a multiply; this result is never expected.
    start_valid = 1'b1;
    funct       = 2'b00;
    op_a        = 32'h12345678;
    op_b        = 32'h0FFFFFFF;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    chk("mid_busy", XLEN'(busy), XLEN'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("divu_9_3", 2'b10, 32'd9, 32'd3, 32'd3, XLEN, XLEN);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", XLEN'(exp_q.size()), XLEN'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
